// File: rtl/div_pkg.sv
// div_pkg: shared constants, state encoding and width helper for the divide-by-10 stage
package div_pkg;
  localparam int DIVISOR = 10;
  localparam int REM_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  function automatic int dividend_w(input int bitsize);
    return bitsize + 4;
  endfunction
endpackage

// File: rtl/div10_step.sv
// div10_step: one restoring-division step by the constant 10
module div10_step
  import div_pkg::*;
(
  input  logic [REM_W:0]   t,
  output logic [REM_W-1:0] r_next,
  output logic             q_bit
);
  // t never exceeds 19, so t-10 always fits the narrower remainder
  always_comb begin
    q_bit = t >= (REM_W+1)'(DIVISOR);
    r_next = q_bit ? REM_W'(t - (REM_W+1)'(DIVISOR)) : t[REM_W-1:0];
  end
endmodule

// File: rtl/sum_mean_div10.sv
// sum_mean_div10: multi-cycle x/10 with valid/ready on both sides and optional round-half-up
module sum_mean_div10
  import div_pkg::*;
#(
  parameter int BITSIZE = 4,
  parameter int ROUND = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BITSIZE+3:0] x,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BITSIZE:0]   quot,
  output logic [REM_W-1:0]   rem
);
  localparam int W = dividend_w(BITSIZE);
  localparam int CW = $clog2(W + 1);
  state_t state, state_nxt;
  logic [W-1:0] dvd;
  logic [BITSIZE:0] q, q_nxt;
  logic [REM_W-1:0] r, r_nxt;
  logic [CW-1:0] cnt;
  logic qb, accept, last, rnd;
  div10_step u_step (.t({r, dvd[W-1]}), .r_next(r_nxt), .q_bit(qb));
  // the quotient fits BITSIZE+1 bits, so bits shifted out the top are always zero
  assign q_nxt = {q[BITSIZE-1:0], qb};
  assign accept = in_valid && in_ready;
  assign last = state == BUSY && cnt == CW'(1);
  assign rnd = ROUND != 0 && r_nxt >= REM_W'(5);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == IDLE ? (in_valid ? BUSY : IDLE) :
                state == BUSY ? (cnt == CW'(1) ? DONE : BUSY) :
                state == DONE ? (out_ready ? (in_valid ? BUSY : IDLE) : DONE) : IDLE;
  end
  always_comb begin
    in_ready = state == IDLE || (state == DONE && out_ready);
    out_valid = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd <= '0;
      q <= '0;
      r <= '0;
      cnt <= '0;
      quot <= '0;
      rem <= '0;
    end else if (accept) begin
      dvd <= x;
      q <= '0;
      r <= '0;
      cnt <= CW'(W);
    end else if (state == BUSY) begin
      dvd <= dvd << 1;
      q <= q_nxt;
      r <= r_nxt;
      cnt <= cnt - CW'(1);
      if (last) begin
        quot <= q_nxt + {{BITSIZE{1'b0}}, rnd};
        rem <= r_nxt;
      end
    end
  end
endmodule
